instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//   Fetch stage of the 5-stage SimpleRISC pipeline. Owns the PC and drives the
//   synchronous-read instruction BRAM. Presents {inst, pc, valid} to the
//   IF/OF pipe register. Supports a hazard stall, a branch redirect with a
//   wrong-path squash, and a sticky halt that is cleared by a later redirect.
// PARAMETERS
//   ADDR_W     7              IM word-address width (128 words)
//   RESET_PC   32'h0000_0000  byte PC loaded at reset
//   NOP_INST   32'h6800_0000  bubble word (SimpleRISC nop)
//   HALT_INST  32'hFFFF_FFFF  instruction word that halts fetch
// PORTS
//   clk            in   1       system clock
//   rst            in   1       asynchronous, active-low reset
//   stall          in   1       hold PC and outputs (load-use or other hazard)
//   isBranchTaken  in   1       redirect request from the branch unit
//   branchPC       in   32      redirect target (byte address, word aligned)
//   IMclka         out  1       IM clock; equals clk
//   IMaddra        out  ADDR_W  IM word address
//   IMdouta        in   32      IM read data; valid 1 cycle after IMaddra is sampled
//   inst           out  32      fetched instruction; NOP_INST when valid=0
//   pc             out  32      byte PC of inst
//   valid          out  1       inst is a real, non-squashed instruction
//   stop           out  1       fetch halted (HALT_INST issued)
// BEHAVIOUR
//   State machine: PRIME, RUN, HALT.
//   - Reset (rst=0, async): state=PRIME, pc_q=RESET_PC. Outputs: valid=0,
//     stop=0, inst=NOP_INST, pc=RESET_PC.
//   Address generation:
//   - next_pc is combinational. IMaddra = next_pc[ADDR_W+1:2], so IMdouta in
//     the following cycle always belongs to pc_q.
//   - Priority: isBranchTaken > state/stall > increment.
//       - isBranchTaken:      next_pc = branchPC
//       - PRIME, HALT, stall: next_pc = pc_q
//       - otherwise:          next_pc = pc_q + 4 (mod 2^32)
//   - Address wrap is modulo 2^ADDR_W words. No error is flagged.
//   PRIME:
//   - Exactly 1 cycle after reset release. Primes the BRAM with RESET_PC.
//   - valid=0. Next state is RUN; pc_q stays RESET_PC.
//   - If isBranchTaken is asserted here, pc_q=branchPC and the state still goes to RUN.
//   RUN:
//   - pc=pc_q. inst=IMdouta.
//   - valid=1 unless isBranchTaken=1 in the same cycle. That instruction is
//     wrong-path, so it is squashed: valid=0, inst=NOP_INST.
//   - stall=1 (no redirect): pc_q and the IM address are held, so inst, pc and
//     valid stay stable. The downstream pipe holds as well.
//   - IMdouta==HALT_INST, valid=1 and stall=0: the halt word is issued as NOP
//     (valid=0). Next state is HALT; pc_q holds the halt's PC.
//   - stall=1 on a HALT_INST defers the halt until stall drops.
//   HALT:
//   - stop=1, valid=0, inst=NOP_INST. PC is frozen and stall is ignored.
//   - isBranchTaken=1: an older branch proves the halt was wrong-path.
//     pc_q=branchPC, state=PRIME, stop=0 on the next cycle.
//   Latency and reset:
//   - Redirect to first valid target instruction: 1 cycle (target appears
//     the cycle after isBranchTaken).
//   - Reset mid-operation: immediate return to PRIME values. No output glitch
//     beyond the reset values.
//   - All state is in pc_q and state. No combinational path from IMdouta to IMaddra.
// TESTING
//   1. Reset, then run: memory words 0..3 = A,B,C,D.
//      -> cycle1 valid=0; then (pc,inst) = (0,A),(4,B),(8,C),(C,D), one per cycle.
//   2. Stall 3 cycles while pc=8.
//      -> inst=C, pc=8, valid=1 held for all 3 cycles; pc=C follows on release.
//   3. isBranchTaken=1, branchPC=0x40, while pc=0x8.
//      -> that cycle valid=0, inst=NOP; next cycle pc=0x40, inst=mem[16], valid=1.
//   4. Stall and redirect asserted together.
//      -> redirect wins: next pc=branchPC, current output squashed.
//   5. HALT_INST at pc=0x10.
//      -> valid=0 and stop=1 from the next cycle, held for 10+ cycles.
//      -> Then redirect to 0x20 -> stop=0, one PRIME cycle, then pc=0x20 valid.
//   6. Wrap and reset: run from pc=0x1FC -> next IMaddra=0 (pc=0x200).
//      -> Assert rst=0 mid-stall -> outputs equal reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//   Fetch stage of the SimpleRISC pipeline. Owns the PC, drives the
//   synchronous-read instruction memory and presents {inst, pc, valid} to the
//   IF/OF pipe register. Handles hazard stall, branch redirect with squash of
//   the wrong-path word, and a sticky halt released by a later redirect.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous, active-low reset
//   stall          in   hold PC and outputs
//   isBranchTaken  in   redirect request from the branch unit
//   branchPC       in   redirect target (byte address, word aligned)
//   IMclka         out  instruction memory clock (same as clk)
//   IMaddra        out  instruction memory word address
//   IMdouta        in   instruction memory read data (1-cycle latency)
//   inst           out  fetched instruction, NOP_INST when valid=0
//   pc             out  byte PC of inst
//   valid          out  inst is a real, non-squashed instruction
//   stop           out  fetch halted
//   fsm_state      out  current FSM state (0=PRIME, 1=RUN, 2=HALT)
//
// Flow control: there is no valid/ready handshake. valid qualifies
// {inst, pc} every cycle; while stall is high (and no redirect) the stage
// holds pc and the memory address, so inst/pc/valid stay stable and the
// consumer is expected to hold as well.
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
    parameter int          ADDR_W    = 7,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h6800_0000,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              isBranchTaken,
    input  logic [31:0]       branchPC,
    output logic              IMclka,
    output logic [ADDR_W-1:0] IMaddra,
    input  logic [31:0]       IMdouta,
    output logic [31:0]       inst,
    output logic [31:0]       pc,
    output logic              valid,
    output logic              stop,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] next_pc;
    logic        halt_hit;

    assign IMclka    = clk;
    assign fsm_state = state_q;

    // The halt word is only acted on when it would otherwise be issued:
    // a redirect squashes it, a stall defers it.
    assign halt_hit = (state_q == S_RUN) && !isBranchTaken && !stall &&
                      (IMdouta == HALT_INST);

    // Address generation. Deliberately independent of IMdouta so there is
    // no combinational path from memory data back to the memory address.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (isBranchTaken) begin
            next_pc = branchPC;
        end else if ((state_q != S_RUN) || stall) begin
            next_pc = pc_q;
        end
    end

    assign IMaddra = next_pc[ADDR_W+1:2];

    // On a halt the memory has already been pointed at pc_q+4, but pc_q
    // keeps the halt's PC; the prefetched word is never used because HALT
    // can only be left through PRIME, which re-reads the memory.
    assign pc_d = halt_hit ? pc_q : next_pc;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_PRIME;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PRIME: state_d = S_RUN;
            S_RUN:   state_d = halt_hit ? S_HALT : S_RUN;
            S_HALT:  state_d = isBranchTaken ? S_PRIME : S_HALT;
            default: state_d = S_PRIME;
        endcase
    end

    // Output logic
    always_comb begin
        valid = 1'b0;
        stop  = 1'b0;
        inst  = NOP_INST;
        pc    = pc_q;
        case (state_q)
            S_RUN: begin
                if (!isBranchTaken && !halt_hit) begin
                    valid = 1'b1;
                    inst  = IMdouta;
                end
            end
            S_HALT:  stop = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
//   Self-checking bench for instr_fetch_stage. A behavioural memory model
//   feeds the fetch stage; a reference model of the fetch rules predicts
//   {valid, stop, pc, inst, IMaddra} every cycle. Inputs are driven on the
//   falling edge and outputs are sampled 2 time units later, well away from
//   the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP  = 32'h6800_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int M_PRIME = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        isBranchTaken = 1'b0;
    logic [31:0] branchPC = 32'h0;
    logic        IMclka;
    logic [6:0]  IMaddra;
    logic [31:0] IMdouta;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        stop;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .isBranchTaken (isBranchTaken),
        .branchPC      (branchPC),
        .IMclka        (IMclka),
        .IMaddra       (IMaddra),
        .IMdouta       (IMdouta),
        .inst          (inst),
        .pc            (pc),
        .valid         (valid),
        .stop          (stop),
        .fsm_state     (fsm_state)
    );

    // Synchronous-read instruction memory
    logic [31:0] mem [128];
    always @(posedge IMclka) IMdouta <= mem[IMaddra];

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int          m_mode;
    logic [31:0] m_pc;
    logic        exp_valid;
    logic        exp_stop;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [6:0]  exp_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[8:2]];
    endfunction

    function automatic string obs();
        return $sformatf("v=%b s=%b pc=%h inst=%h addr=%0d",
                         valid, stop, pc, inst, IMaddra);
    endfunction

    function automatic string want();
        return $sformatf("v=%b s=%b pc=%h inst=%h addr=%0d",
                         exp_valid, exp_stop, exp_pc, exp_inst, exp_addr);
    endfunction

    // Drive one cycle of inputs and compute what the fetch rules predict.
    task automatic step(input logic s, input logic b, input logic [31:0] t);
        logic [31:0] w;
        logic [31:0] na;
        @(negedge clk);
        stall = s;
        isBranchTaken = b;
        branchPC = t;
        #2;
        w = word_at(m_pc);
        exp_pc    = m_pc;
        exp_stop  = (m_mode == M_HALT);
        exp_valid = 1'b0;
        exp_inst  = NOP;
        if (m_mode == M_RUN && !b && !(w == HALT && !s)) begin
            exp_valid = 1'b1;
            exp_inst  = w;
        end
        if (b) na = t;
        else if (m_mode != M_RUN || s) na = m_pc;
        else na = m_pc + 32'd4;
        exp_addr = na[8:2];
    endtask

    // Let the rising edge happen and move the model forward.
    task automatic advance();
        logic [31:0] w;
        w = word_at(m_pc);
        @(posedge clk);
        case (m_mode)
            M_PRIME: begin
                if (isBranchTaken) m_pc = branchPC;
                m_mode = M_RUN;
            end
            M_RUN: begin
                if (isBranchTaken) m_pc = branchPC;
                else if (stall) m_pc = m_pc;
                else if (w == HALT) m_mode = M_HALT;
                else m_pc = m_pc + 32'd4;
            end
            default: begin
                if (isBranchTaken) begin
                    m_pc = branchPC;
                    m_mode = M_PRIME;
                end
            end
        endcase
    endtask

    // Reset and release just after a rising edge, so the next step's
    // falling edge observes the PRIME cycle.
    task automatic do_reset();
        rst = 1'b0;
        stall = 1'b0;
        isBranchTaken = 1'b0;
        branchPC = 32'h0;
        m_mode = M_PRIME;
        m_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom();
            if (mem[i] == HALT) mem[i] = 32'h1234_5678;
        end
        mem[0] = 32'hAAAA_0001;
        mem[1] = 32'hBBBB_0002;
        mem[2] = 32'hCCCC_0003;
        mem[3] = 32'hDDDD_0004;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if ({valid, stop, pc, inst} !== {1'b0, 1'b0, 32'h0, NOP}) begin
            failures++;
            $display("FAIL reset_values got v=%b s=%b pc=%h inst=%h want v=0 s=0 pc=0 inst=%h",
                     valid, stop, pc, inst, NOP);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp_pcs [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
        logic        exp_vs  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL run_model cyc=%0d got %s want %s", i, obs(), want());
            end
            checks++;
            if (pc !== exp_pcs[i] || valid !== exp_vs[i] ||
                (i > 0 && inst !== mem[i-1])) begin
                failures++;
                $display("FAIL run_seq cyc=%0d got pc=%h v=%b inst=%h want pc=%h v=%b",
                         i, pc, valid, inst, exp_pcs[i], exp_vs[i]);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            // cycles 3..5 present pc=8 under stall
            step((i >= 3 && i <= 5), 1'b0, 32'h0);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL stall_model cyc=%0d got %s want %s", i, obs(), want());
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (pc !== 32'h8 || inst !== mem[2] || valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got pc=%h inst=%h v=%b want pc=8 inst=%h v=1",
                             i, pc, inst, valid, mem[2]);
                end
            end
            if (i == 7) begin
                checks++;
                if (pc !== 32'hC || valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_release got pc=%h v=%b want pc=c v=1", pc, valid);
                end
            end
            advance();
        end
    endtask

    task automatic test_branch(input logic with_stall, input logic [31:0] tgt);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            // cycle 3 presents pc=8 and carries the redirect
            if (i == 3) step(with_stall, 1'b1, tgt);
            else step(1'b0, 1'b0, 32'h0);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL branch_model st=%b cyc=%0d got %s want %s", with_stall, i, obs(), want());
            end
            if (i == 3) begin
                checks++;
                if (valid !== 1'b0 || inst !== NOP || pc !== 32'h8) begin
                    failures++;
                    $display("FAIL branch_squash st=%b got v=%b inst=%h pc=%h want v=0 inst=%h pc=8",
                             with_stall, valid, inst, pc, NOP);
                end
            end
            if (i == 4) begin
                checks++;
                if (valid !== 1'b1 || pc !== tgt || inst !== mem[tgt[8:2]]) begin
                    failures++;
                    $display("FAIL branch_target st=%b got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             with_stall, valid, pc, inst, tgt, mem[tgt[8:2]]);
                end
            end
            advance();
        end
    endtask

    task automatic test_halt();
        mem[4] = HALT;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            // 0 prime, 1..5 pc 0..0x10, 6..17 halted, 18 redirect, 19 prime, 20.. run at 0x20
            if (i == 18) step(1'b0, 1'b1, 32'h20);
            else if (i >= 6 && i < 18) step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
            else step(1'b0, 1'b0, 32'h0);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL halt_model cyc=%0d got %s want %s", i, obs(), want());
            end
            if (i == 5 || (i >= 6 && i <= 19)) begin
                checks++;
                if (valid !== 1'b0 || inst !== NOP || stop !== (i >= 6 && i <= 18)) begin
                    failures++;
                    $display("FAIL halt_stop cyc=%0d got v=%b s=%b inst=%h want v=0 s=%b",
                             i, valid, stop, inst, (i >= 6 && i <= 18));
                end
            end
            if (i == 20) begin
                checks++;
                if (valid !== 1'b1 || pc !== 32'h20 || inst !== mem[8] || stop !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_resume got v=%b s=%b pc=%h inst=%h want v=1 s=0 pc=20 inst=%h",
                             valid, stop, pc, inst, mem[8]);
                end
            end
            advance();
        end
        mem[4] = 32'h4444_0005;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1'b0, 1'b1, 32'h1FC);
            else step((i == 3), 1'b0, 32'h0);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL wrap_model cyc=%0d got %s want %s", i, obs(), want());
            end
            if (i == 1) begin
                checks++;
                if (pc !== 32'h1FC || IMaddra !== 7'd0 || inst !== mem[127]) begin
                    failures++;
                    $display("FAIL wrap_addr got pc=%h addr=%0d inst=%h want pc=1fc addr=0 inst=%h",
                             pc, IMaddra, inst, mem[127]);
                end
            end
            if (i == 2) begin
                checks++;
                if (pc !== 32'h200 || inst !== mem[0] || valid !== 1'b1) begin
                    failures++;
                    $display("FAIL wrap_pc got pc=%h inst=%h v=%b want pc=200 inst=%h v=1",
                             pc, inst, valid, mem[0]);
                end
            end
            if (i < 3) advance();
        end
        // Mid-stall, between clock edges: reset must act immediately.
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({valid, stop, pc, inst} !== {1'b0, 1'b0, 32'h0, NOP}) begin
            failures++;
            $display("FAIL async_reset got v=%b s=%b pc=%h inst=%h want v=0 s=0 pc=0 inst=%h",
                     valid, stop, pc, inst, NOP);
        end
    endtask

    task automatic test_random();
        fill_mem();
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 15) == 0) mem[i] = HALT;
        end
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic s;
            logic b;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            step(s, b, t);
            checks++;
            if ({valid, stop, pc, inst, IMaddra} !== {exp_valid, exp_stop, exp_pc, exp_inst, exp_addr}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got %s want %s", i, obs(), want());
            end
            advance();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        fill_mem();
        test_reset();
        test_run();
        test_stall();
        test_branch(1'b0, 32'h40);
        test_branch(1'b1, 32'h80);
        test_halt();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
